// File: rtl/song_sequencer_if.sv
// Bundle between the key/counter side and the song sequencer.
// master: debounced keys plus ROM address counter feedback, consumes the
//         song selection and counter controls.
// slave:  the song sequencer itself.
interface song_sequencer_if;
    logic       KEY_PLAY;
    logic       KEY_NEXT;
    logic       KEY_PREV;
    logic       MODE_LOOP;
    logic       ADDR_TICK;
    logic [9:0] CNT8;
    logic [3:0] STATE;
    logic [9:0] start_addr;
    logic [9:0] end_addr;
    logic       LOAD;
    logic       RUN;
    logic [1:0] SONG_IDX;

    modport master (
        output KEY_PLAY, KEY_NEXT, KEY_PREV, MODE_LOOP, ADDR_TICK, CNT8,
        input  STATE, start_addr, end_addr, LOAD, RUN, SONG_IDX
    );

    modport slave (
        input  KEY_PLAY, KEY_NEXT, KEY_PREV, MODE_LOOP, ADDR_TICK, CNT8,
        output STATE, start_addr, end_addr, LOAD, RUN, SONG_IDX
    );
endinterface

// File: rtl/song_sequencer.sv
// Playback controller: picks the active song, tells the ROM address counter
// where the song lives, and issues the reload pulse and run enable.
// Every output is a flop; the song decode is taken from the next index so
// the addresses are already valid in the cycle LOAD is high.
module song_sequencer #(
    parameter logic [9:0] S0_START     = 10'd0,
    parameter logic [9:0] S0_END       = 10'd255,
    parameter logic [9:0] S1_START     = 10'd256,
    parameter logic [9:0] S1_END       = 10'd511,
    parameter logic [9:0] S2_START     = 10'd512,
    parameter logic [9:0] S2_END       = 10'd767,
    parameter logic [9:0] S3_START     = 10'd768,
    parameter logic [9:0] S3_END       = 10'd1023,
    parameter bit         STOP_AT_LAST = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    song_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        PLAY   = 2'd2,
        PAUSE  = 2'd3
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] state_q, state_d;
    logic [9:0] start_q, start_d;
    logic [9:0] end_q, end_d;
    logic       load_q, load_d;
    logic       run_q, run_d;
    logic       end_evt;

    // Next state and next song; one event per cycle, play > next > prev > end.
    always_comb begin
        fsm_d   = fsm_q;
        idx_d   = idx_q;
        end_evt = bus.ADDR_TICK && (bus.CNT8 >= end_q);
        case (fsm_q)
            IDLE: begin
                if (bus.KEY_PLAY) begin
                    fsm_d = RELOAD;
                end else if (bus.KEY_NEXT) begin
                    idx_d = idx_q + 2'd1;
                end else if (bus.KEY_PREV) begin
                    idx_d = idx_q - 2'd1;
                end
            end
            RELOAD: begin
                fsm_d = PLAY;
            end
            PLAY: begin
                if (bus.KEY_PLAY) begin
                    fsm_d = PAUSE;
                end else if (bus.KEY_NEXT) begin
                    idx_d = idx_q + 2'd1;
                    fsm_d = RELOAD;
                end else if (bus.KEY_PREV) begin
                    idx_d = idx_q - 2'd1;
                    fsm_d = RELOAD;
                end else if (end_evt) begin
                    if (bus.MODE_LOOP) begin
                        fsm_d = RELOAD;
                    end else if (STOP_AT_LAST && (idx_q == 2'd3)) begin
                        idx_d = 2'd0;
                        fsm_d = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        fsm_d = RELOAD;
                    end
                end
            end
            PAUSE: begin
                if (bus.KEY_PLAY) begin
                    fsm_d = PLAY;
                end else if (bus.KEY_NEXT) begin
                    idx_d = idx_q + 2'd1;
                    fsm_d = RELOAD;
                end else if (bus.KEY_PREV) begin
                    idx_d = idx_q - 2'd1;
                    fsm_d = RELOAD;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state and next song index.
    always_comb begin
        state_d = 4'b0001;
        start_d = S0_START;
        end_d   = S0_END;
        case (idx_d)
            2'd0: begin state_d = 4'b0001; start_d = S0_START; end_d = S0_END; end
            2'd1: begin state_d = 4'b0010; start_d = S1_START; end_d = S1_END; end
            2'd2: begin state_d = 4'b0100; start_d = S2_START; end_d = S2_END; end
            2'd3: begin state_d = 4'b1000; start_d = S3_START; end_d = S3_END; end
            default: begin state_d = 4'b0001; start_d = S0_START; end_d = S0_END; end
        endcase
        load_d = (fsm_d == RELOAD);
        run_d  = (fsm_d == PLAY);
    end

    // State and output registers; reset wins over any key in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q   <= IDLE;
            idx_q   <= 2'd0;
            state_q <= 4'b0001;
            start_q <= S0_START;
            end_q   <= S0_END;
            load_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            load_q  <= load_d;
            run_q   <= run_d;
        end
    end

    assign bus.SONG_IDX   = idx_q;
    assign bus.STATE      = state_q;
    assign bus.start_addr = start_q;
    assign bus.end_addr   = end_q;
    assign bus.LOAD       = load_q;
    assign bus.RUN        = run_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a table of one-cycle vectors for the
// wrapping build, plus a hand-written sequence for the stop-at-last build.
module tb_song_sequencer;

    logic clk;
    logic rstA;
    logic rstB;

    song_sequencer_if ifA ();
    song_sequencer_if ifB ();

    song_sequencer #(.STOP_AT_LAST(1'b0)) dutA (
        .CLK (clk),
        .RST (rstA),
        .bus (ifA.slave)
    );

    song_sequencer #(.STOP_AT_LAST(1'b1)) dutB (
        .CLK (clk),
        .RST (rstB),
        .bus (ifB.slave)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       play;
        logic       next;
        logic       prev;
        logic       loop;
        logic       tick;
        logic [9:0] cnt;
        logic [1:0] idx;
        logic       load;
        logic       run;
    } vec_t;

    vec_t vecs[$];
    int   vectorCount;
    int   missCount;

    // Queue one cycle of stimulus and the outputs expected after that edge.
    task automatic addVector(input logic rst, input logic play, input logic next,
                             input logic prev, input logic loop, input logic tick,
                             input logic [9:0] cnt, input logic [1:0] idx,
                             input logic load, input logic run);
        vec_t v;
        v.rst = rst; v.play = play; v.next = next; v.prev = prev;
        v.loop = loop; v.tick = tick; v.cnt = cnt;
        v.idx = idx; v.load = load; v.run = run;
        vecs.push_back(v);
    endtask

    // Drive one vector into the wrapping build.
    task automatic applyStimulus(input vec_t v);
        rstA          = v.rst;
        ifA.KEY_PLAY  = v.play;
        ifA.KEY_NEXT  = v.next;
        ifA.KEY_PREV  = v.prev;
        ifA.MODE_LOOP = v.loop;
        ifA.ADDR_TICK = v.tick;
        ifA.CNT8      = v.cnt;
    endtask

    // Compare every output against the song layout: song k spans k*256..k*256+255.
    task automatic checkOutput(input string name, input logic [1:0] aIdx,
                               input logic [3:0] aState, input logic [9:0] aStart,
                               input logic [9:0] aEnd, input logic aLoad,
                               input logic aRun, input logic [1:0] eIdx,
                               input logic eLoad, input logic eRun);
        logic [3:0] eState;
        logic [9:0] eStart;
        logic [9:0] eEnd;
        eState = 4'b0001 << eIdx;
        eStart = {eIdx, 8'h00};
        eEnd   = {eIdx, 8'hFF};
        vectorCount++;
        if (aIdx !== eIdx || aState !== eState || aStart !== eStart ||
            aEnd !== eEnd || aLoad !== eLoad || aRun !== eRun) begin
            missCount++;
            $display("[TB] FAIL %s: got idx=%0d state=%b start=%0d end=%0d load=%b run=%b, want idx=%0d state=%b start=%0d end=%0d load=%b run=%b",
                     name, aIdx, aState, aStart, aEnd, aLoad, aRun,
                     eIdx, eState, eStart, eEnd, eLoad, eRun);
        end
    endtask

    // One cycle on the stop-at-last build, then check it.
    task automatic stepB(input string name, input logic rst, input logic play,
                         input logic next, input logic prev, input logic loop,
                         input logic tick, input logic [9:0] cnt,
                         input logic [1:0] eIdx, input logic eLoad, input logic eRun);
        @(negedge clk);
        rstB          = rst;
        ifB.KEY_PLAY  = play;
        ifB.KEY_NEXT  = next;
        ifB.KEY_PREV  = prev;
        ifB.MODE_LOOP = loop;
        ifB.ADDR_TICK = tick;
        ifB.CNT8      = cnt;
        @(posedge clk);
        #1;
        checkOutput(name, ifB.SONG_IDX, ifB.STATE, ifB.start_addr, ifB.end_addr,
                    ifB.LOAD, ifB.RUN, eIdx, eLoad, eRun);
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rstA = 1'b1;
        rstB = 1'b1;
        ifA.KEY_PLAY = 0; ifA.KEY_NEXT = 0; ifA.KEY_PREV = 0;
        ifA.MODE_LOOP = 0; ifA.ADDR_TICK = 0; ifA.CNT8 = '0;
        ifB.KEY_PLAY = 0; ifB.KEY_NEXT = 0; ifB.KEY_PREV = 0;
        ifB.MODE_LOOP = 0; ifB.ADDR_TICK = 0; ifB.CNT8 = '0;

        //        rst pl nx pv lp tk cnt    idx ld rn
        addVector(1, 0, 0, 0, 0, 0, 10'd0,    0, 0, 0); // reset state
        addVector(1, 1, 1, 0, 0, 0, 10'd0,    0, 0, 0); // keys ignored under reset
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    0, 0, 0); // idle
        addVector(0, 1, 0, 0, 0, 0, 10'd0,    0, 1, 0); // play -> reload song 0
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    0, 0, 1); // run
        addVector(0, 0, 0, 0, 0, 1, 10'd100,  0, 0, 1); // mid-song tick
        addVector(0, 0, 0, 0, 0, 1, 10'd255,  1, 1, 0); // end -> song 1
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    1, 0, 1);
        addVector(0, 0, 0, 0, 1, 1, 10'd511,  1, 1, 0); // loop-one reload
        addVector(0, 0, 0, 0, 1, 0, 10'd0,    1, 0, 1);
        addVector(0, 0, 1, 0, 0, 1, 10'd511,  2, 1, 0); // next + end: one advance
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    2, 0, 1);
        addVector(0, 0, 1, 0, 0, 0, 10'd0,    3, 1, 0); // next -> song 3
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    3, 0, 1);
        addVector(0, 0, 0, 0, 0, 1, 10'd1023, 0, 1, 0); // song 3 end wraps
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    0, 0, 1);
        addVector(0, 0, 0, 1, 0, 0, 10'd0,    3, 1, 0); // prev at song 0 -> 3
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    3, 0, 1);
        addVector(0, 1, 0, 0, 0, 0, 10'd0,    3, 0, 0); // pause
        addVector(0, 0, 0, 0, 0, 1, 10'd1023, 3, 0, 0); // tick ignored in pause
        addVector(0, 1, 0, 0, 0, 0, 10'd0,    3, 0, 1); // resume, no load
        addVector(0, 1, 1, 0, 0, 0, 10'd0,    3, 0, 0); // play+next -> pause only
        addVector(0, 0, 1, 0, 0, 0, 10'd0,    0, 1, 0); // next in pause -> reload
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    0, 0, 1);
        addVector(0, 1, 0, 0, 0, 1, 10'd255,  0, 0, 0); // play+end -> pause, end dropped
        addVector(0, 1, 0, 0, 0, 0, 10'd0,    0, 0, 1); // resume
        addVector(0, 0, 0, 0, 0, 1, 10'd600,  1, 1, 0); // cnt past end still ends
        addVector(0, 0, 1, 0, 0, 0, 10'd0,    1, 0, 1); // reload ignores keys
        addVector(0, 0, 1, 0, 0, 0, 10'd0,    2, 1, 0); // reload song 2
        addVector(1, 1, 0, 0, 0, 0, 10'd0,    0, 0, 0); // reset during reload
        addVector(0, 0, 0, 0, 0, 0, 10'd0,    0, 0, 0);
        addVector(0, 0, 1, 0, 0, 0, 10'd0,    1, 0, 0); // idle next, no load
        addVector(0, 0, 0, 1, 0, 0, 10'd0,    0, 0, 0); // idle prev
        addVector(0, 0, 0, 1, 0, 0, 10'd0,    3, 0, 0); // idle prev wraps
        addVector(0, 0, 0, 0, 0, 1, 10'd1023, 3, 0, 0); // idle ignores end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vecA%0d", i), ifA.SONG_IDX, ifA.STATE,
                        ifA.start_addr, ifA.end_addr, ifA.LOAD, ifA.RUN,
                        vecs[i].idx, vecs[i].load, vecs[i].run);
        end

        //    name          rst pl nx pv lp tk cnt     idx ld rn
        stepB("B_reset",    1, 0, 0, 0, 0, 0, 10'd0,    0, 0, 0);
        stepB("B_prev",     0, 0, 0, 1, 0, 0, 10'd0,    3, 0, 0);
        stepB("B_play",     0, 1, 0, 0, 0, 0, 10'd0,    3, 1, 0);
        stepB("B_run",      0, 0, 0, 0, 0, 0, 10'd0,    3, 0, 1);
        stepB("B_loop3",    0, 0, 0, 0, 1, 1, 10'd1023, 3, 1, 0);
        stepB("B_run2",     0, 0, 0, 0, 0, 0, 10'd0,    3, 0, 1);
        stepB("B_stop",     0, 0, 0, 0, 0, 1, 10'd1023, 0, 0, 0);
        stepB("B_idle1",    0, 0, 0, 0, 0, 0, 10'd0,    0, 0, 0);
        stepB("B_idle2",    0, 0, 0, 0, 0, 1, 10'd255,  0, 0, 0);
        stepB("B_replay",   0, 1, 0, 0, 0, 0, 10'd0,    0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
